// File: rtl/arb_pkg.sv
// Shared types for the arbiter output buffer: stored beat layout, frame FSM states
// and mode encodings.
package arb_pkg;

  localparam int ARB_DW = 32;

  localparam logic [1:0] MODE_INACTIVE = 2'b00;

  typedef struct packed {
    logic              src;
    logic [1:0]        mode;
    logic [7:0]        proc_val;
    logic [ARB_DW-1:0] data;
  } arb_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } frame_state_e;

endpackage

// File: rtl/arb_fifo_mem.sv
// Register-array storage for the arbiter output FIFO: one synchronous write port,
// one asynchronous read port so the head is available in the same cycle.
module arb_fifo_mem
  import arb_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  arb_entry_t    wdata,
  input  logic [AW-1:0] raddr,
  output arb_entry_t    rdata
);

  arb_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/arb_out_fifo.sv
// First-word-fall-through buffer between the two-slave arbiter and master-0, with a
// frame-completion tracker that counts drained beats against a programmed length.
module arb_out_fifo
  import arb_pkg::*;
#(
  parameter int DW       = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int FLW      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  input  logic [DW-1:0]            wr_data,
  input  logic [1:0]               wr_mode,
  input  logic [7:0]               wr_proc_val,
  input  logic                     wr_src,
  output logic                     fifo_full,
  output logic                     almost_full,
  output logic                     fifo_empty,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DW-1:0]            rd_data,
  output logic [1:0]               rd_mode,
  output logic [7:0]               rd_proc_val,
  output logic                     rd_src,
  input  logic [FLW-1:0]           frame_len,
  input  logic                     cmplt_clr,
  output logic                     mstr0_cmplt,
  output logic                     overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  if (DW != ARB_DW) begin : g_dw_check
    $error("arb_out_fifo: DW must equal arb_pkg::ARB_DW");
  end

  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [OW-1:0]  occ;
  logic           push;
  logic           pop;
  arb_entry_t     wr_entry;
  arb_entry_t     head;
  frame_state_e   state;
  logic [FLW-1:0] frame_cnt;
  logic [FLW-1:0] len_q;

  // Flags come from the registered count, so they lag the causing edge by one cycle.
  assign fifo_full   = (occ == OW'(DEPTH));
  assign almost_full = (occ >= OW'(AF_LEVEL));
  assign fifo_empty  = (occ == '0);
  assign occupancy   = occ;
  assign rd_valid    = !fifo_empty;

  assign push = wr_valid && !fifo_full;
  assign pop  = rd_valid && rd_ready;

  assign wr_entry = '{src: wr_src, mode: wr_mode, proc_val: wr_proc_val, data: wr_data};

  arb_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Stale array contents never leak out: an empty FIFO presents an all-zero head.
  assign rd_data     = fifo_empty ? '0            : head.data;
  assign rd_mode     = fifo_empty ? MODE_INACTIVE : head.mode;
  assign rd_proc_val = fifo_empty ? '0            : head.proc_val;
  assign rd_src      = fifo_empty ? 1'b0          : head.src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
      if (wr_valid && fifo_full) begin
        overflow_err <= 1'b1;
      end
    end
  end

  // Frame tracker: pops while DONE drain freely but are not counted toward a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      frame_cnt   <= '0;
      len_q       <= '0;
      mstr0_cmplt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop && (frame_len != '0)) begin
            len_q     <= frame_len;
            frame_cnt <= FLW'(1);
            if (frame_len == FLW'(1)) begin
              state       <= DONE;
              mstr0_cmplt <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (pop) begin
            frame_cnt <= frame_cnt + FLW'(1);
            if ((frame_cnt + FLW'(1)) == len_q) begin
              state       <= DONE;
              mstr0_cmplt <= 1'b1;
            end
          end
        end
        DONE: begin
          if (cmplt_clr) begin
            state       <= IDLE;
            frame_cnt   <= '0;
            mstr0_cmplt <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
